ikari_gfx_rom_arbiter: RTL and testbench
========================================

# ikari_gfx_rom_arbiter

Shares the single SDRAM graphics-ROM channel between the background and sprite tile fetchers. Requesters use a toggle req/ack handshake: `req != ack` means pending, and `req == ack` means data is valid and held. The block does round-robin arbitration, keeps a one-entry hit cache per requester, and refetches once when the requester's address moves while its fetch is in flight. It sits between the layer cores (for example the background-1 tile ROM address generator) and the SDRAM controller port.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (index 0 = back1, 1 = back2, 2 = sprites)
- AW, 24, ROM word address width
- DW, 16, ROM data width

Ports (name, direction, width, meaning):
- clk  in  1  video/system clock; the single clock domain
- VIDEO_RSTn  in  1  asynchronous active-low reset
- req_tgl  in  NUM_REQ  per-requester request toggle
- req_addr  in  NUM_REQ*AW  per-requester address; requester i uses bits [i*AW +: AW]
- ack_tgl  out  NUM_REQ  per-requester acknowledge toggle
- req_data  out  NUM_REQ*DW  per-requester data, held stable while ack_tgl[i] == req_tgl[i]
- sdram_addr  out  AW  address to the SDRAM controller
- sdram_req  out  1  SDRAM request toggle
- sdram_ack  in  1  SDRAM acknowledge toggle; sdram_data is valid when sdram_ack == sdram_req
- sdram_data  in  DW  SDRAM read data
- busy  out  1  high while an SDRAM transaction is outstanding
- grant_id  out  $clog2(NUM_REQ)  index of the last or current grant

## Operation
- pending[i] = req_tgl[i] ^ ack_tgl[i].
- Per-requester state:
  - cache_addr[i] (AW), cache_vld[i].
  - req_data[i] doubles as the cached data.
- Round-robin search starts at (last_grant+1) mod NUM_REQ and picks the first pending index.
- State machine IDLE / WAIT:
  - IDLE with no pending requester: stay in IDLE.
  - IDLE, winner g, cache hit (cache_vld[g] && cache_addr[g] == req_addr[g]):
    - ack_tgl[g] <= req_tgl[g]; req_data[g] unchanged.
    - last_grant <= g; stay in IDLE.
  - IDLE, winner g, cache miss:
    - lat_addr <= req_addr[g]; sdram_addr <= req_addr[g].
    - sdram_req <= ~sdram_req; grant_id <= g; refetched <= 0.
    - busy <= 1; go to WAIT.
  - WAIT while sdram_ack != sdram_req: hold everything.
  - WAIT completion (sdram_ack == sdram_req), case 1: req_addr[g] == lat_addr, or refetched == 1:
    - req_data[g] <= sdram_data.
    - cache_addr[g] <= lat_addr; cache_vld[g] <= 1.
    - ack_tgl[g] <= req_tgl[g]; last_grant <= g.
    - busy <= 0; go to IDLE.
  - WAIT completion, case 2: req_addr[g] != lat_addr and refetched == 0 (stale):
    - Discard the data.
    - lat_addr and sdram_addr <= the new req_addr[g]; toggle sdram_req.
    - refetched <= 1; stay in WAIT.
- After a stale first fetch, the second fetch is acknowledged regardless of address movement. This bounds the service time to 2 transactions.
- Requesters follow the rule "on address change, req <= ~ack". A requester toggling while already pending is illegal. The arbiter does not check for it.
- ack_tgl[i] is only written from req_tgl[i], so it never overshoots a request.
- cache_vld is cleared only by reset.

## Timing
- Reset values: sdram_req=0, sdram_addr=0, ack_tgl=0, req_data=0, busy=0, grant_id=0, cache_vld=0, state=IDLE, last_grant=NUM_REQ-1 (so requester 0 is served first after reset).
- Cache-hit latency: ack_tgl updates on the first edge after pending is visible in IDLE, i.e. 1 cycle.
- Miss issue: sdram_req toggles on the first edge in IDLE with the request pending. sdram_addr is valid on that same edge.
- Miss completion:
  - The edge at which sdram_ack == sdram_req is first sampled updates req_data and ack_tgl together.
  - The next request can be issued one cycle later. IDLE always consumes one cycle.
- Refetch: reissue on the completion edge, with no IDLE cycle in between.
- Simultaneous pending requests are served in round-robin order, one grant per IDLE cycle.
- req_data[i] changes only on the same edge as ack_tgl[i].
- Reset asserted mid-WAIT aborts the transaction and all state returns to reset values. The SDRAM controller is reset by the same VIDEO_RSTn, so its toggle realigns.

## Test plan
- Single miss:
  - Stimulus: req0 addr 0x004123, SDRAM acks after 5 cycles with data 0xA55A.
  - Required: sdram_req toggles 1 cycle after the request; ack_tgl[0] toggles on the ack-sample edge; req_data[0]=0xA55A.
- Cache hit:
  - Stimulus: re-request req0 with the same address 0x004123.
  - Required: ack_tgl[0] follows in 1 cycle; no sdram_req toggle; req_data[0] unchanged.
- Round-robin:
  - Stimulus: req0, req1, req2 all pending at once with misses.
  - Required: grant order 0,1,2. Then with req0 and req2 pending again, the order is 0,2.
- Stale refetch:
  - Stimulus: req1 addr 0x010000 in flight; addr changes to 0x010004 before the ack.
  - Required: second sdram_req with addr 0x010004; req1 is acknowledged with the second data only.
- Double move:
  - Stimulus: the address also changes during the refetch.
  - Required: the requester is acknowledged after the 2nd transaction with that data; cache_addr = second latched address.
- Reset mid-WAIT:
  - Stimulus: assert VIDEO_RSTn low while busy=1.
  - Required: all outputs go to 0 asynchronously; after release, a new req0 is served normally.

Source files
------------

// File: rtl/ikari_gfx_rom_arbiter_if.sv
// ikari_gfx_rom_arbiter_if
//   Bundles the requester-side toggle handshake and the SDRAM-side toggle
//   handshake of the graphics-ROM arbiter.
//
//   Requester side : req_tgl, req_addr (in to arbiter); ack_tgl, req_data (out)
//   SDRAM side     : sdram_ack, sdram_data (in to arbiter);
//                    sdram_addr, sdram_req (out)
//   Status         : busy, grant_id (out)
//
//   modport slave  : the arbiter's view
//   modport master : the view of whatever surrounds the arbiter
//                    (layer cores + SDRAM controller, or a bench)
interface ikari_gfx_rom_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 24,
  parameter int DW      = 16,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]    req_tgl;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ-1:0]    ack_tgl;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [AW-1:0]         sdram_addr;
  logic                  sdram_req;
  logic                  sdram_ack;
  logic [DW-1:0]         sdram_data;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  modport slave (
    input  req_tgl, req_addr, sdram_ack, sdram_data,
    output ack_tgl, req_data, sdram_addr, sdram_req, busy, grant_id
  );

  modport master (
    output req_tgl, req_addr, sdram_ack, sdram_data,
    input  ack_tgl, req_data, sdram_addr, sdram_req, busy, grant_id
  );
endinterface

// File: rtl/ikari_gfx_rom_arbiter.sv
// ikari_gfx_rom_arbiter
//   Shares one SDRAM graphics-ROM channel between the tile fetchers
//   (0 = back1, 1 = back2, 2 = sprites). Toggle req/ack handshake on both
//   sides, round-robin arbitration, a one-entry hit cache per requester
//   (req_data doubles as the cached word), and a single refetch when the
//   requester's address moves while its fetch is in flight.
//
//   Ports:
//     clk        : single clock domain
//     VIDEO_RSTn : asynchronous active-low reset
//     bus        : ikari_gfx_rom_arbiter_if.slave (requester + SDRAM handshakes,
//                  busy, grant_id)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | pick a pending requester; serve hits, issue misses
//   S_WAIT | SDRAM transaction outstanding for requester r_grant_id
module ikari_gfx_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 24,
  parameter int DW      = 16
) (
  input logic                    clk,
  input logic                    VIDEO_RSTn,
  ikari_gfx_rom_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [GW-1:0]               r_last_grant;
  logic [GW-1:0]               r_grant_id;
  logic [AW-1:0]               r_lat_addr;
  logic                        r_refetched;
  logic [NUM_REQ-1:0][AW-1:0]  r_cache_addr;
  logic [NUM_REQ-1:0]          r_cache_vld;
  logic [NUM_REQ-1:0]          r_ack_tgl;
  logic [NUM_REQ-1:0][DW-1:0]  r_req_data;
  logic [AW-1:0]               r_sdram_addr;
  logic                        r_sdram_req;
  logic                        r_busy;

  logic [NUM_REQ-1:0][AW-1:0]  w_req_addr;
  logic [NUM_REQ-1:0]          w_pending;
  logic                        w_found;
  logic [GW-1:0]               w_winner;
  logic [GW-1:0]               w_idx;
  logic [AW-1:0]               w_win_addr;
  logic [AW-1:0]               w_cur_addr;
  logic                        w_sdram_done;
  logic                        w_hit;
  logic                        w_issue;
  logic                        w_done;
  logic                        w_refetch;

  assign w_req_addr   = bus.req_addr;
  assign w_pending    = bus.req_tgl ^ r_ack_tgl;
  assign w_win_addr   = w_req_addr[w_winner];
  assign w_cur_addr   = w_req_addr[r_grant_id];
  assign w_sdram_done = (bus.sdram_ack == r_sdram_req);

  // Round-robin: first pending index starting just after the last grant.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && w_pending[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_refetch   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          if (r_cache_vld[w_winner] && (r_cache_addr[w_winner] == w_win_addr)) begin
            w_hit = 1'b1;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_sdram_done) begin
          // A second fetch is always accepted so service time stays bounded.
          if ((w_cur_addr == r_lat_addr) || r_refetched) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_refetch = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_lat_addr   <= '0;
      r_refetched  <= 1'b0;
      r_cache_addr <= '0;
      r_cache_vld  <= '0;
      r_ack_tgl    <= '0;
      r_req_data   <= '0;
      r_sdram_addr <= '0;
      r_sdram_req  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_hit) begin
        r_ack_tgl[w_winner] <= bus.req_tgl[w_winner];
        r_last_grant        <= w_winner;
      end
      if (w_issue) begin
        r_lat_addr   <= w_win_addr;
        r_sdram_addr <= w_win_addr;
        r_sdram_req  <= ~r_sdram_req;
        r_grant_id   <= w_winner;
        r_refetched  <= 1'b0;
        r_busy       <= 1'b1;
      end
      if (w_done) begin
        r_req_data[r_grant_id]   <= bus.sdram_data;
        r_cache_addr[r_grant_id] <= r_lat_addr;
        r_cache_vld[r_grant_id]  <= 1'b1;
        r_ack_tgl[r_grant_id]    <= bus.req_tgl[r_grant_id];
        r_last_grant             <= r_grant_id;
        r_busy                   <= 1'b0;
      end
      if (w_refetch) begin
        r_lat_addr   <= w_cur_addr;
        r_sdram_addr <= w_cur_addr;
        r_sdram_req  <= ~r_sdram_req;
        r_refetched  <= 1'b1;
      end
    end
  end

  assign bus.ack_tgl    = r_ack_tgl;
  assign bus.req_data   = r_req_data;
  assign bus.sdram_addr = r_sdram_addr;
  assign bus.sdram_req  = r_sdram_req;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_grant_id;
endmodule

// File: tb/tb_ikari_gfx_rom_arbiter.sv
// tb_ikari_gfx_rom_arbiter
//   Directed bench for the graphics-ROM arbiter with an SDRAM responder model
//   and an ack scoreboard (expected requester id + data per acknowledge).
module tb_ikari_gfx_rom_arbiter;
  localparam int NUM_REQ = 3;
  localparam int AW      = 24;
  localparam int DW      = 16;
  localparam int SD_LAT  = 4;

  logic clk = 1'b0;
  logic VIDEO_RSTn = 1'b0;

  ikari_gfx_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) bus ();

  ikari_gfx_rom_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .VIDEO_RSTn (VIDEO_RSTn),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ROM contents seen through the SDRAM model.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a == 24'h004123) return 16'hA55A;
    return a[15:0] ^ {a[23:16], 8'h3C};
  endfunction

  // SDRAM responder: acks a toggle request SD_LAT+1 edges after seeing it.
  logic          sd_ack;
  logic [DW-1:0] sd_data;
  logic [AW-1:0] sd_lat_addr;
  int            sd_cnt;
  assign bus.sdram_ack  = sd_ack;
  assign bus.sdram_data = sd_data;

  always @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      sd_ack      <= 1'b0;
      sd_data     <= '0;
      sd_lat_addr <= '0;
      sd_cnt      <= 0;
    end else if (bus.sdram_req != sd_ack) begin
      if (sd_cnt == 0) begin
        sd_cnt      <= 1;
        sd_lat_addr <= bus.sdram_addr;
      end else if (sd_cnt == SD_LAT) begin
        sd_data <= rom_f(sd_lat_addr);
        sd_ack  <= bus.sdram_req;
        sd_cnt  <= 0;
      end else begin
        sd_cnt <= sd_cnt + 1;
      end
    end
  end

  int sd_toggles = 0;
  always @(bus.sdram_req) if (VIDEO_RSTn) sd_toggles++;

  // Scoreboard of expected acknowledges, in order.
  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push(input int i, input logic [DW-1:0] d);
    exp_t e;
    e.id   = 2'(i);
    e.data = d;
    sb.push_back(e);
  endtask

  logic [NUM_REQ-1:0]    mon_prev_ack;
  logic [NUM_REQ*DW-1:0] mon_prev_data;
  initial begin
    exp_t e;
    mon_prev_ack  = '0;
    mon_prev_data = '0;
    forever begin
      @(posedge clk or negedge VIDEO_RSTn);
      #1;
      if (!VIDEO_RSTn) begin
        mon_prev_ack  = '0;
        mon_prev_data = '0;
        sb.delete();
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.ack_tgl[i] !== mon_prev_ack[i]) begin
            n_checks++;
            assert (sb.size() > 0) else begin
              n_errors++;
              $error("FAIL sb_unexpected_ack: observed ack from %0d expected none", i);
            end
            if (sb.size() > 0) begin
              e = sb.pop_front();
              chk("sb_ack_id", 32'(i), 32'(e.id));
              chk("sb_ack_data", 32'(bus.req_data[i*DW +: DW]), 32'(e.data));
            end
          end else if (bus.req_data[i*DW +: DW] !== mon_prev_data[i*DW +: DW]) begin
            chk("data_hold_without_ack", 32'(bus.req_data[i*DW +: DW]),
                32'(mon_prev_data[i*DW +: DW]));
          end
        end
        mon_prev_ack  = bus.ack_tgl;
        mon_prev_data = bus.req_data;
      end
    end
  end

  task automatic drive_req(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_tgl[i] = ~bus.req_tgl[i];
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic wait_ack(input int i, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (bus.ack_tgl[i] === bus.req_tgl[i]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(bus.ack_tgl), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_sreq"},  32'(bus.sdram_req), 32'd0);
    chk({tag, "_saddr"}, 32'(bus.sdram_addr), 32'd0);
    chk({tag, "_gid"},   32'(bus.grant_id), 32'd0);
    chk({tag, "_data"},  32'(bus.req_data[31:0]), 32'd0);
    chk({tag, "_data2"}, 32'(bus.req_data[47:32]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  ok;
    bus.req_tgl  = '0;
    bus.req_addr = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    VIDEO_RSTn = 1'b1;

    // Single miss
    @(negedge clk);
    drive_req(0, 24'h004123);
    push(0, 16'hA55A);
    @(posedge clk); #1;
    chk("miss_issue_toggle", 32'(bus.sdram_req), 32'd1);
    chk("miss_issue_addr", 32'(bus.sdram_addr), 32'h004123);
    chk("miss_busy", 32'(bus.busy), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.sdram_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("miss_sdram_ack_seen", 32'(ok), 32'd1);
    chk("miss_ack_not_early", 32'(bus.ack_tgl[0]), 32'd0);
    @(posedge clk); #1;
    chk("miss_ack_on_sample", 32'(bus.ack_tgl[0]), 32'd1);
    chk("miss_data", 32'(bus.req_data[15:0]), 32'hA55A);
    chk("miss_busy_clear", 32'(bus.busy), 32'd0);

    // Cache hit
    @(negedge clk);
    base = sd_toggles;
    drive_req(0, 24'h004123);
    push(0, 16'hA55A);
    @(posedge clk); #1;
    chk("hit_ack_1cyc", 32'(bus.ack_tgl[0]), 32'd0);
    chk("hit_no_sdram", 32'(sd_toggles - base), 32'd0);
    chk("hit_data_kept", 32'(bus.req_data[15:0]), 32'hA55A);

    // Serve req2 alone so the round-robin pointer sits at 2
    @(negedge clk);
    drive_req(2, 24'h000200);
    push(2, rom_f(24'h000200));
    wait_ack(2, 40, "prep2_ack");

    // Round-robin: all three pending -> 0,1,2
    @(negedge clk);
    drive_req(0, 24'h000300);
    drive_req(1, 24'h000310);
    drive_req(2, 24'h000320);
    push(0, rom_f(24'h000300));
    push(1, rom_f(24'h000310));
    push(2, rom_f(24'h000320));
    wait_ack(0, 60, "rr3_ack0");
    wait_ack(1, 60, "rr3_ack1");
    wait_ack(2, 60, "rr3_ack2");
    chk("rr3_drained", 32'(sb.size()), 32'd0);

    // Round-robin: 0 and 2 pending -> 0,2
    @(negedge clk);
    drive_req(0, 24'h000400);
    drive_req(2, 24'h000420);
    push(0, rom_f(24'h000400));
    push(2, rom_f(24'h000420));
    wait_ack(0, 60, "rr2_ack0");
    wait_ack(2, 60, "rr2_ack2");
    chk("rr2_drained", 32'(sb.size()), 32'd0);

    // Stale refetch
    @(negedge clk);
    base = sd_toggles;
    drive_req(1, 24'h010000);
    push(1, rom_f(24'h010004));
    @(negedge clk);
    @(negedge clk);
    set_addr(1, 24'h010004);
    wait_ack(1, 40, "stale_ack");
    chk("stale_two_fetches", 32'(sd_toggles - base), 32'd2);
    chk("stale_refetch_addr", 32'(bus.sdram_addr), 32'h010004);
    chk("stale_data", 32'(bus.req_data[31:16]), 32'(rom_f(24'h010004)));

    // Double move
    @(negedge clk);
    base = sd_toggles;
    drive_req(1, 24'h020000);
    push(1, rom_f(24'h020008));
    @(negedge clk);
    @(negedge clk);
    set_addr(1, 24'h020008);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.sdram_addr === 24'h020008) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dbl_refetch_seen", 32'(ok), 32'd1);
    set_addr(1, 24'h02000C);
    wait_ack(1, 40, "dbl_ack");
    chk("dbl_two_fetches", 32'(sd_toggles - base), 32'd2);
    chk("dbl_data", 32'(bus.req_data[31:16]), 32'(rom_f(24'h020008)));
    // cache_addr must hold the second latched address: re-request it and expect a hit
    @(negedge clk);
    base = sd_toggles;
    drive_req(1, 24'h020008);
    push(1, rom_f(24'h020008));
    @(posedge clk); #1;
    chk("dbl_cache_hit_ack", 32'(bus.ack_tgl[1]), 32'(bus.req_tgl[1]));
    chk("dbl_cache_hit_nofetch", 32'(sd_toggles - base), 32'd0);

    // Reset mid-WAIT
    @(negedge clk);
    drive_req(0, 24'h030000);
    @(posedge clk); #1;
    chk("rstw_busy", 32'(bus.busy), 32'd1);
    #2;
    VIDEO_RSTn   = 1'b0;
    bus.req_tgl  = '0;
    #1;
    chk_all_zero("rstw");
    @(negedge clk);
    @(negedge clk);
    VIDEO_RSTn = 1'b1;
    @(negedge clk);
    base = sd_toggles;
    drive_req(0, 24'h004123);
    push(0, 16'hA55A);
    wait_ack(0, 40, "post_rst_ack");
    chk("post_rst_miss", 32'(sd_toggles - base), 32'd1);
    chk("post_rst_data", 32'(bus.req_data[15:0]), 32'hA55A);

    @(negedge clk);
    chk("final_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
